// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame scheduler and the hd44780 driver.
// Holds the scheduler state encoding, the space character and buffer geometry.
package lcd_pkg;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int RAW   = 7;

    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ACK,
        S_RUN,
        S_HOLD
    } state_t;

endpackage

// File: rtl/lcd_frame_scheduler_if.sv
// Client write, driver read and driver handshake bundle of the frame scheduler.
// master: clients/driver side; slave: the scheduler (gnt, rd_data, lcd_trg, dirty, ack_err out).
interface lcd_frame_scheduler_if
    import lcd_pkg::*;
();

    logic [1:0]      req;
    logic [2*AW-1:0] req_addr;
    logic [15:0]     req_data;
    logic [1:0]      gnt;
    logic [RAW-1:0]  rd_addr;
    logic [7:0]      rd_data;
    logic            force_refresh;
    logic            lcd_busy;
    logic            lcd_trg;
    logic            dirty;
    logic            ack_err;

    modport master (
        output req, req_addr, req_data, rd_addr, force_refresh, lcd_busy,
        input  gnt, rd_data, lcd_trg, dirty, ack_err
    );

    modport slave (
        input  req, req_addr, req_data, rd_addr, force_refresh, lcd_busy,
        output gnt, rd_data, lcd_trg, dirty, ack_err
    );

endinterface

// File: rtl/lcd_rr_arbiter2.sv
// Two-way round-robin arbiter; a client whose grant is still high is not eligible.
// Ports: clk, rst (async, active-low), req, gnt_q in; winner, valid out.
module lcd_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] gnt_q,
    output logic       winner,
    output logic       valid
);

    logic       last_q;
    logic [1:0] elig;

    // gnt_q masking stops a second write while the client drops req
    assign elig  = req & ~gnt_q;
    assign valid = |elig;

    always_comb begin
        winner = 1'b0;
        unique case (elig)
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_q;
            default: winner = 1'b0;
        endcase
    end

    // last_q resets to 1 so client 0 wins the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else if (valid) begin
            last_q <= winner;
        end
    end

endmodule

// File: rtl/lcd_frame_scheduler.sv
// 32-cell shadow frame buffer with two arbitrated writers, a driver read port and refresh scheduler.
// Ports: clk, rst (async, active-low), bus (slave): client req/gnt, rd port, lcd_busy/lcd_trg, dirty, ack_err.
module lcd_frame_scheduler
    import lcd_pkg::*;
#(
    parameter int HOLDOFF = 2500,
    parameter int ACK_TO  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    lcd_frame_scheduler_if.slave  bus
);

    localparam int HW = $clog2(HOLDOFF + 1);
    localparam int CW = $clog2(ACK_TO + 1);

    logic [7:0]    mem [DEPTH];
    logic [7:0]    rd_q;
    logic [1:0]    gnt_q;
    logic          win;
    logic          win_vld;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    state_t        state_q, state_d;
    logic          dirty_q, dirty_d;
    logic          trg_q, trg_d;
    logic          err_q, err_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [CW-1:0] ack_q, ack_d;

    lcd_rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req),
        .gnt_q  (gnt_q),
        .winner (win),
        .valid  (win_vld)
    );

    assign wr_addr = win ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
    assign wr_data = win ? bus.req_data[15:8] : bus.req_data[7:0];

    // Buffer, registered read port and grant pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= SPACE;
            end
            rd_q  <= SPACE;
            gnt_q <= 2'b00;
        end else begin
            if (win_vld) begin
                mem[wr_addr] <= wr_data;
            end
            // cells beyond the buffer read as blanks for the driver's 128-cell walk
            if (bus.rd_addr < RAW'(DEPTH)) begin
                rd_q <= mem[bus.rd_addr[AW-1:0]];
            end else begin
                rd_q <= SPACE;
            end
            if (win_vld) begin
                gnt_q <= win ? 2'b10 : 2'b01;
            end else begin
                gnt_q <= 2'b00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INIT;
            dirty_q <= 1'b0;
            trg_q   <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            dirty_q <= dirty_d;
            trg_q   <= trg_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dirty_d = dirty_q;
        trg_d   = 1'b0;
        err_d   = err_q;
        hold_d  = hold_q;
        ack_d   = ack_q;
        unique case (state_q)
            S_INIT: begin
                if (!bus.lcd_busy) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (dirty_q && !bus.lcd_busy) begin
                    trg_d   = 1'b1;
                    dirty_d = 1'b0;
                    ack_d   = '0;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (bus.lcd_busy) begin
                    state_d = S_RUN;
                end else if (ack_q == CW'(ACK_TO - 1)) begin
                    err_d   = 1'b1;
                    dirty_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ack_d = ack_q + CW'(1);
                end
            end
            S_RUN: begin
                if (!bus.lcd_busy) begin
                    hold_d  = HW'(HOLDOFF - 1);
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.lcd_busy) begin
                    state_d = S_RUN;
                end else if (hold_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = S_INIT;
        endcase
        // a write or forced refresh on the trigger edge keeps the frame dirty
        if (win_vld || bus.force_refresh) begin
            dirty_d = 1'b1;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.rd_data = rd_q;
    assign bus.lcd_trg = trg_q;
    assign bus.dirty   = dirty_q;
    assign bus.ack_err = err_q;

endmodule
